// File: rtl/lcd_fb_arbiter_if.sv
// Signal bundle between the framebuffer arbiter and its three neighbours:
// the LCD scan-out engine, the host writer and the single-port framebuffer RAM.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface lcd_fb_arbiter_if;
  // LCD scan-out side
  logic [7:0]  lcd_x;
  logic [2:0]  lcd_y;
  logic [7:0]  pixels;
  logic        frame_strobe;
  // Host write side
  logic        frame_hold;
  logic        wr_req;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  // Framebuffer RAM side
  logic [10:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  modport slave (
    input  lcd_x, lcd_y, frame_hold, wr_req, wr_addr, wr_data, ram_rdata,
    output pixels, frame_strobe, wr_ack, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output lcd_x, lcd_y, frame_hold, wr_req, wr_addr, wr_data, ram_rdata,
    input  pixels, frame_strobe, wr_ack, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/lcd_fb_arbiter.sv
// Framebuffer arbiter: shares one 240x8-byte single-port synchronous RAM
// between LCD scan-out reads and host writes, keeps the LCD's pixel byte
// coherent with host writes, and paces frames with a periodic frame strobe
// that the host can defer for tear-free updates.
module lcd_fb_arbiter #(
  parameter int FRAME_CYCLES  = 800000,
  parameter int STROBE_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  lcd_fb_arbiter_if.slave bus
);

  localparam int TW = $clog2(FRAME_CYCLES + 1);
  localparam int SW = $clog2(STROBE_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(FRAME_CYCLES - 1);
  localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_CYCLES - 1);
  localparam logic [7:0]    PANEL_W     = 8'd240;
  localparam logic [10:0]   FB_BYTES    = 11'd1920;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RD     = 2'd1,
    S_RD_CAP = 2'd2,
    S_WR     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pixels_q, pixels_d;
  logic [10:0] cur_addr_q, cur_addr_d;
  logic        cur_valid_q, cur_valid_d;
  logic [10:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        ram_we_q, ram_we_d;
  logic        wr_ack_q, wr_ack_d;

  logic [TW-1:0] timer_q, timer_d;
  logic [SW-1:0] strobe_cnt_q, strobe_cnt_d;
  logic          strobe_q, strobe_d;
  logic          pending_q, pending_d;

  logic [10:0] y_ext;
  logic [10:0] lcd_addr;
  logic        off_panel;
  logic        wrap;

  // y*240 without a multiplier: (y<<8) - (y<<4); the sum stays below 2048.
  assign y_ext     = {8'd0, bus.lcd_y};
  assign lcd_addr  = (y_ext << 8) - (y_ext << 4) + {3'd0, bus.lcd_x};
  assign off_panel = (bus.lcd_x >= PANEL_W);
  assign wrap      = (timer_q == TIMER_LAST);

  // Access arbitration: LCD reads win over host writes, one action per clk.
  always_comb begin
    state_d     = state_q;
    pixels_d    = pixels_q;
    cur_addr_d  = cur_addr_q;
    cur_valid_d = cur_valid_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = ram_we_q;
    wr_ack_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (off_panel) begin
          // Blanking columns show black and force a fresh read on return.
          pixels_d    = 8'd0;
          cur_valid_d = 1'b0;
        end else if (!cur_valid_q || (lcd_addr != cur_addr_q)) begin
          ram_addr_d  = lcd_addr;
          ram_we_d    = 1'b0;
          cur_addr_d  = lcd_addr;
          cur_valid_d = 1'b1;
          state_d     = S_RD;
        end else if (bus.wr_req && !wr_ack_q) begin
          // The ack cycle ignores wr_req so a still-held request is not
          // written twice; out-of-range writes are acked but never reach RAM.
          state_d = S_WR;
          if (bus.wr_addr < FB_BYTES) begin
            ram_addr_d  = bus.wr_addr;
            ram_wdata_d = bus.wr_data;
            ram_we_d    = 1'b1;
          end
        end
      end
      S_RD: begin
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        pixels_d = bus.ram_rdata;
        state_d  = S_IDLE;
      end
      S_WR: begin
        ram_we_d = 1'b0;
        wr_ack_d = 1'b1;
        // ram_we_q marks an in-range write; ram_addr_q equals the held wr_addr.
        // Bypass keeps pixels coherent without spending a re-read.
        if (ram_we_q && cur_valid_q && (ram_addr_q == cur_addr_q)) begin
          pixels_d = ram_wdata_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Arbiter state and registered RAM/LCD outputs; reset aborts any access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pixels_q    <= 8'd0;
      cur_addr_q  <= 11'd0;
      cur_valid_q <= 1'b0;
      ram_addr_q  <= 11'd0;
      ram_wdata_q <= 8'd0;
      ram_we_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pixels_q    <= pixels_d;
      cur_addr_q  <= cur_addr_d;
      cur_valid_q <= cur_valid_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      wr_ack_q    <= wr_ack_d;
    end
  end

  // Frame pacing: free-running timer, fixed-width strobe, deferral by frame_hold.
  always_comb begin
    timer_d      = wrap ? '0 : timer_q + 1'b1;
    strobe_d     = strobe_q;
    strobe_cnt_d = strobe_cnt_q;
    pending_d    = pending_q;
    if (strobe_q) begin
      // A wrap while the strobe is high is dropped, never queued.
      if (strobe_cnt_q == '0) begin
        strobe_d = 1'b0;
      end else begin
        strobe_cnt_d = strobe_cnt_q - 1'b1;
      end
    end else if (pending_q) begin
      if (!bus.frame_hold) begin
        strobe_d     = 1'b1;
        strobe_cnt_d = STROBE_LAST;
        pending_d    = 1'b0;
      end
    end else if (wrap) begin
      if (!bus.frame_hold) begin
        strobe_d     = 1'b1;
        strobe_cnt_d = STROBE_LAST;
      end else begin
        pending_d = 1'b1;
      end
    end
  end

  // Frame timer and strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q      <= '0;
      strobe_cnt_q <= '0;
      strobe_q     <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      strobe_cnt_q <= strobe_cnt_d;
      strobe_q     <= strobe_d;
      pending_q    <= pending_d;
    end
  end

  assign bus.pixels       = pixels_q;
  assign bus.frame_strobe = strobe_q;
  assign bus.wr_ack       = wr_ack_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_wdata    = ram_wdata_q;
  assign bus.ram_we       = ram_we_q;

endmodule
